// File: rtl/cnt_stream_checker.sv
// cnt_stream_checker: locks onto an incrementing counter stream, counts sequence errors while locked.
// Optional CHK_BADCAP_EN adds capture of the first locked mismatch (bad_data/bad_exp/bad_valid).
module cnt_stream_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
`ifdef CHK_BADCAP_EN
  ,
  output logic [WIDTH-1:0] bad_data,
  output logic [WIDTH-1:0] bad_exp,
  output logic             bad_valid
`endif
);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] expected, expected_n, seed;
  logic [3:0] good, good_n, good_inc;
  logic miss, miss_n, pulse_n, match;
  logic [ERR_W-1:0] cnt_n;
  assign seed = data_in + WIDTH'(1);
  assign match = data_in == expected;
  assign good_inc = good + 4'd1;
  always_comb begin
    state_n = state;
    expected_n = expected;
    good_n = good;
    miss_n = miss;
    pulse_n = 1'b0;
    cnt_n = err_cnt;
    if (clear) begin
      state_n = HUNT;
      good_n = '0;
      miss_n = 1'b0;
      cnt_n = '0;
    end else if (valid_in) begin
      expected_n = seed;
      case (state)
        HUNT: begin
          good_n = '0;
          state_n = SYNC;
        end
        SYNC: begin
          good_n = match ? good_inc : '0;
          state_n = (match && good_inc == 4'(LOCK_CNT)) ? LOCKED : SYNC;
        end
        LOCKED: begin
          pulse_n = !match;
          cnt_n = (match || &err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
          miss_n = !match && !miss;
          state_n = (!match && miss) ? HUNT : LOCKED;
        end
        default: state_n = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HUNT;
      expected <= '0;
      good <= '0;
      miss <= 1'b0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      expected <= expected_n;
      good <= good_n;
      miss <= miss_n;
      locked <= state_n == LOCKED;
      err_pulse <= pulse_n;
      err_cnt <= cnt_n;
    end
`ifdef CHK_BADCAP_EN
  // Only the first locked mismatch since reset/clear is kept.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bad_data <= '0;
      bad_exp <= '0;
      bad_valid <= 1'b0;
    end else if (clear) begin
      bad_data <= '0;
      bad_exp <= '0;
      bad_valid <= 1'b0;
    end else if (valid_in && state == LOCKED && !match && !bad_valid) begin
      bad_data <= data_in;
      bad_exp <= expected;
      bad_valid <= 1'b1;
    end
`endif
endmodule
